// File: rtl/nstacks_param_if.sv
// +----------------------------------------------------------------------+
// | nstacks_param_if : request/status bundle for the multi-stack bank    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface nstacks_param_if #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 16,
  parameter int NUM_STACKS = 4
);
  localparam int SEL_W = (NUM_STACKS > 1) ? $clog2(NUM_STACKS) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  STACK_ENB;
  logic [SEL_W-1:0]      STACK_SEL;
  logic                  STACK_push_flag;
  logic                  STACK_pop_flag;
  logic [DATA_W-1:0]     STACK_push_value;
  logic                  STACK_clear;
  logic [DATA_W-1:0]     STACK_TOP;
  logic [CNT_W-1:0]      STACK_AMOUNT;
  logic                  STACK_FULL;
  logic                  STACK_EMPTY;
  logic [DATA_W-1:0]     STACK_pop_data;
  logic                  STACK_pop_valid;
  logic [NUM_STACKS-1:0] STACK_overflow;
  logic [NUM_STACKS-1:0] STACK_underflow;

  modport master (
    output STACK_ENB, STACK_SEL, STACK_push_flag, STACK_pop_flag,
           STACK_push_value, STACK_clear,
    input  STACK_TOP, STACK_AMOUNT, STACK_FULL, STACK_EMPTY,
           STACK_pop_data, STACK_pop_valid, STACK_overflow, STACK_underflow
  );

  modport slave (
    input  STACK_ENB, STACK_SEL, STACK_push_flag, STACK_pop_flag,
           STACK_push_value, STACK_clear,
    output STACK_TOP, STACK_AMOUNT, STACK_FULL, STACK_EMPTY,
           STACK_pop_data, STACK_pop_valid, STACK_overflow, STACK_underflow
  );
endinterface

`default_nettype wire

// File: rtl/nstacks_param.sv
// +----------------------------------------------------------------------+
// | nstacks_param : bank of NUM_STACKS register-based LIFO stacks        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module nstacks_param #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 16,
  parameter int NUM_STACKS = 4
) (
  input  wire               clock,
  input  wire               reset_n,
  nstacks_param_if.slave    bus
);
  localparam int SEL_W = (NUM_STACKS > 1) ? $clog2(NUM_STACKS) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(DEPTH);

  logic [DATA_W-1:0]     r_mem [NUM_STACKS][DEPTH];
  logic [CNT_W-1:0]      r_cnt [NUM_STACKS];
  logic [NUM_STACKS-1:0] r_ovf;
  logic [NUM_STACKS-1:0] r_unf;
  logic [DATA_W-1:0]     r_pop_data;
  logic                  r_pop_valid;

  logic                  w_sel_ok;
  logic [SEL_W-1:0]      w_idx;
  logic [CNT_W-1:0]      w_cnt;
  logic [IDX_W-1:0]      w_top_ptr;
  logic [IDX_W-1:0]      w_wr_ptr;
  logic [DATA_W-1:0]     w_top;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_op;
  logic                  w_do_clear;
  logic                  w_do_replace;
  logic                  w_do_push;
  logic                  w_do_pop;
  logic                  w_do_ovf;
  logic                  w_do_unf;

  // Only a non-power-of-two bank can be addressed out of range.
  generate
    if ((2 ** SEL_W) == NUM_STACKS) begin : g_sel_dense
      assign w_sel_ok = 1'b1;
    end else begin : g_sel_sparse
      assign w_sel_ok = (bus.STACK_SEL < SEL_W'(NUM_STACKS));
    end
  endgenerate

  assign w_idx     = w_sel_ok ? bus.STACK_SEL : '0;
  assign w_cnt     = w_sel_ok ? r_cnt[w_idx] : '0;
  assign w_empty   = (w_cnt == '0);
  assign w_full    = (w_cnt == c_full_cnt);
  assign w_top_ptr = IDX_W'(w_cnt - CNT_W'(1));
  assign w_wr_ptr  = IDX_W'(w_cnt);
  assign w_top     = w_empty ? '0 : r_mem[w_idx][w_top_ptr];

  assign w_op         = reset_n && bus.STACK_ENB && w_sel_ok && !bus.STACK_clear;
  assign w_do_clear   = reset_n && bus.STACK_ENB && w_sel_ok && bus.STACK_clear;
  // push+pop on an empty stack degrades to a plain push, never an underflow
  assign w_do_replace = w_op && bus.STACK_push_flag && bus.STACK_pop_flag && !w_empty;
  assign w_do_push    = w_op && bus.STACK_push_flag && (!bus.STACK_pop_flag || w_empty)
                        && !w_full;
  assign w_do_ovf     = w_op && bus.STACK_push_flag && !bus.STACK_pop_flag && w_full;
  assign w_do_pop     = w_op && bus.STACK_pop_flag && !bus.STACK_push_flag && !w_empty;
  assign w_do_unf     = w_op && bus.STACK_pop_flag && !bus.STACK_push_flag && w_empty;

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_STACKS; i++) begin
        r_cnt[i] <= '0;
      end
      r_ovf       <= '0;
      r_unf       <= '0;
      r_pop_data  <= '0;
      r_pop_valid <= 1'b0;
    end else begin
      r_pop_valid <= 1'b0;
      if (w_do_clear) begin
        r_cnt[w_idx] <= '0;
        r_ovf[w_idx] <= 1'b0;
        r_unf[w_idx] <= 1'b0;
      end
      if (w_do_push) begin
        r_cnt[w_idx] <= w_cnt + CNT_W'(1);
      end
      if (w_do_pop) begin
        r_cnt[w_idx] <= w_cnt - CNT_W'(1);
      end
      if (w_do_pop || w_do_replace) begin
        r_pop_data  <= w_top;
        r_pop_valid <= 1'b1;
      end
      if (w_do_ovf) begin
        r_ovf[w_idx] <= 1'b1;
      end
      if (w_do_unf) begin
        r_unf[w_idx] <= 1'b1;
      end
    end
  end

  // Storage carries no reset; entries above the count are never observed.
  always_ff @(negedge clock) begin
    if (w_do_push) begin
      r_mem[w_idx][w_wr_ptr] <= bus.STACK_push_value;
    end else if (w_do_replace) begin
      r_mem[w_idx][w_top_ptr] <= bus.STACK_push_value;
    end
  end

  assign bus.STACK_TOP       = w_top;
  assign bus.STACK_AMOUNT    = w_cnt;
  assign bus.STACK_FULL      = w_full;
  assign bus.STACK_EMPTY     = w_empty;
  assign bus.STACK_pop_data  = r_pop_data;
  assign bus.STACK_pop_valid = r_pop_valid;
  assign bus.STACK_overflow  = r_ovf;
  assign bus.STACK_underflow = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_nstacks_param.sv
// +----------------------------------------------------------------------+
// | tb_nstacks_param : scoreboard bench for the nstacks_param bank       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_nstacks_param;
  localparam int DATA_W     = 32;
  localparam int DEPTH      = 16;
  localparam int NUM_STACKS = 4;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;
  logic [DATA_W-1:0] exp_q [$];

  nstacks_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_STACKS(NUM_STACKS)) bus ();

  nstacks_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_STACKS(NUM_STACKS)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial begin
    clock = 1'b1;
    forever #5 clock = ~clock;
  end

  // Scoreboard consumer: every pop_valid pulse must match the oldest expectation.
  always begin
    @(negedge clock);
    #1;
    if (bus.STACK_pop_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_pop: got pop_data=%h with no pending expectation",
                 bus.STACK_pop_data);
      end else begin
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        if (bus.STACK_pop_data !== e) begin
          errors++;
          $display("FAIL sb_pop_data: got %h expected %h", bus.STACK_pop_data, e);
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.STACK_ENB        = 1'b0;
    bus.STACK_push_flag  = 1'b0;
    bus.STACK_pop_flag   = 1'b0;
    bus.STACK_clear      = 1'b0;
    bus.STACK_push_value = '0;
  endtask

  // One enabled operation executed at the next negedge; returns 1 ns after it.
  task automatic op(input int sel, input bit push, input bit pop, input bit clr,
                    input logic [DATA_W-1:0] val);
    bus.STACK_ENB        = 1'b1;
    bus.STACK_SEL        = 2'(sel);
    bus.STACK_push_flag  = push;
    bus.STACK_pop_flag   = pop;
    bus.STACK_clear      = clr;
    bus.STACK_push_value = val;
    @(negedge clock);
    #1;
    idle_inputs();
  endtask

  task automatic select(input int sel);
    bus.STACK_SEL = 2'(sel);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    bus.STACK_SEL = '0;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if ({bus.STACK_TOP, bus.STACK_AMOUNT, bus.STACK_EMPTY, bus.STACK_FULL}
        !== {32'h0, 5'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_status: top=%h amount=%0d empty=%b full=%b expected 0/0/1/0",
               bus.STACK_TOP, bus.STACK_AMOUNT, bus.STACK_EMPTY, bus.STACK_FULL);
    end
    checks++;
    if ({bus.STACK_pop_data, bus.STACK_pop_valid, bus.STACK_overflow, bus.STACK_underflow}
        !== {32'h0, 1'b0, 4'b0, 4'b0}) begin
      errors++;
      $display("FAIL reset_regs: pop_data=%h valid=%b ovf=%b unf=%b expected all zero",
               bus.STACK_pop_data, bus.STACK_pop_valid, bus.STACK_overflow,
               bus.STACK_underflow);
    end
    @(posedge clock);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_basic();
    op(0, 1, 0, 0, 32'h11);
    op(0, 1, 0, 0, 32'h22);
    op(0, 1, 0, 0, 32'h33);
    checks++;
    if (bus.STACK_AMOUNT !== 5'd3 || bus.STACK_TOP !== 32'h33) begin
      errors++;
      $display("FAIL basic_push: amount=%0d top=%h expected 3/33", bus.STACK_AMOUNT,
               bus.STACK_TOP);
    end
    exp_q.push_back(32'h33);
    op(0, 0, 1, 0, '0);
    checks++;
    if (bus.STACK_pop_valid !== 1'b1 || bus.STACK_AMOUNT !== 5'd2 ||
        bus.STACK_TOP !== 32'h22) begin
      errors++;
      $display("FAIL basic_pop: valid=%b amount=%0d top=%h expected 1/2/22",
               bus.STACK_pop_valid, bus.STACK_AMOUNT, bus.STACK_TOP);
    end
    @(negedge clock);
    #1;
    checks++;
    if (bus.STACK_pop_valid !== 1'b0 || bus.STACK_pop_data !== 32'h33) begin
      errors++;
      $display("FAIL basic_pulse: valid=%b data=%h expected 0/33", bus.STACK_pop_valid,
               bus.STACK_pop_data);
    end
    op(0, 0, 0, 1, '0);
    checks++;
    if (exp_q.size() != 0 || bus.STACK_EMPTY !== 1'b1) begin
      errors++;
      $display("FAIL basic_drain: pending=%0d empty=%b expected 0/1", exp_q.size(),
               bus.STACK_EMPTY);
    end
  endtask

  task automatic test_full_empty();
    for (int v = 1; v <= DEPTH + 1; v++) op(1, 1, 0, 0, DATA_W'(v));
    checks++;
    if (bus.STACK_AMOUNT !== 5'd16 || bus.STACK_FULL !== 1'b1 ||
        bus.STACK_TOP !== 32'd16 || bus.STACK_overflow !== 4'b0010) begin
      errors++;
      $display("FAIL full: amount=%0d full=%b top=%h ovf=%b expected 16/1/10/0010",
               bus.STACK_AMOUNT, bus.STACK_FULL, bus.STACK_TOP, bus.STACK_overflow);
    end
    for (int v = DEPTH; v >= 1; v--) begin
      exp_q.push_back(DATA_W'(v));
      op(1, 0, 1, 0, '0);
    end
    checks++;
    if (bus.STACK_EMPTY !== 1'b1 || bus.STACK_underflow !== 4'b0000 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: empty=%b unf=%b pending=%0d expected 1/0000/0",
               bus.STACK_EMPTY, bus.STACK_underflow, exp_q.size());
    end
    op(1, 0, 1, 0, '0);
    checks++;
    if (bus.STACK_underflow !== 4'b0010 || bus.STACK_pop_data !== 32'd1 ||
        bus.STACK_pop_valid !== 1'b0) begin
      errors++;
      $display("FAIL underflow: unf=%b data=%h valid=%b expected 0010/1/0",
               bus.STACK_underflow, bus.STACK_pop_data, bus.STACK_pop_valid);
    end
  endtask

  task automatic test_replace();
    op(2, 1, 0, 0, 32'hA);
    exp_q.push_back(32'hA);
    op(2, 1, 1, 0, 32'hB);
    checks++;
    if (bus.STACK_pop_valid !== 1'b1 || bus.STACK_TOP !== 32'hB ||
        bus.STACK_AMOUNT !== 5'd1) begin
      errors++;
      $display("FAIL replace: valid=%b top=%h amount=%0d expected 1/b/1",
               bus.STACK_pop_valid, bus.STACK_TOP, bus.STACK_AMOUNT);
    end
    op(3, 1, 1, 0, 32'hC);
    checks++;
    if (bus.STACK_AMOUNT !== 5'd1 || bus.STACK_TOP !== 32'hC ||
        bus.STACK_pop_valid !== 1'b0 || bus.STACK_underflow[3] !== 1'b0) begin
      errors++;
      $display("FAIL replace_empty: amount=%0d top=%h valid=%b unf=%b expected 1/c/0/0xxx",
               bus.STACK_AMOUNT, bus.STACK_TOP, bus.STACK_pop_valid, bus.STACK_underflow);
    end
  endtask

  task automatic test_interleave();
    op(3, 0, 0, 1, '0);
    op(3, 0, 1, 0, '0);
    op(0, 1, 0, 0, 32'h5);
    op(3, 1, 0, 0, 32'h6);
    exp_q.push_back(32'h5);
    op(0, 0, 1, 0, '0);
    select(3);
    checks++;
    if (bus.STACK_AMOUNT !== 5'd1 || bus.STACK_TOP !== 32'h6 ||
        bus.STACK_underflow !== 4'b1010) begin
      errors++;
      $display("FAIL interleave: amount=%0d top=%h unf=%b expected 1/6/1010",
               bus.STACK_AMOUNT, bus.STACK_TOP, bus.STACK_underflow);
    end
    op(3, 1, 0, 1, 32'h77);
    checks++;
    if (bus.STACK_AMOUNT !== 5'd0 || bus.STACK_underflow !== 4'b0010 ||
        bus.STACK_overflow !== 4'b0010 || bus.STACK_TOP !== 32'h0) begin
      errors++;
      $display("FAIL clear: amount=%0d unf=%b ovf=%b top=%h expected 0/0010/0010/0",
               bus.STACK_AMOUNT, bus.STACK_underflow, bus.STACK_overflow, bus.STACK_TOP);
    end
  endtask

  task automatic test_async_and_enable();
    op(0, 1, 0, 0, 32'h1);
    op(0, 1, 0, 0, 32'h2);
    op(0, 1, 0, 0, 32'h3);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.STACK_AMOUNT, bus.STACK_TOP, bus.STACK_overflow, bus.STACK_underflow,
         bus.STACK_pop_data} !== {5'd0, 32'h0, 4'b0, 4'b0, 32'h0}) begin
      errors++;
      $display("FAIL async_reset: amount=%0d top=%h ovf=%b unf=%b data=%h expected zeros",
               bus.STACK_AMOUNT, bus.STACK_TOP, bus.STACK_overflow, bus.STACK_underflow,
               bus.STACK_pop_data);
    end
    #2;
    reset_n = 1'b1;
    bus.STACK_SEL        = '0;
    bus.STACK_ENB        = 1'b0;
    bus.STACK_push_flag  = 1'b1;
    bus.STACK_push_value = 32'h99;
    @(negedge clock);
    #1;
    checks++;
    if (bus.STACK_AMOUNT !== 5'd0 || bus.STACK_pop_valid !== 1'b0 ||
        bus.STACK_TOP !== 32'h0) begin
      errors++;
      $display("FAIL enable_off: amount=%0d valid=%b top=%h expected 0/0/0",
               bus.STACK_AMOUNT, bus.STACK_pop_valid, bus.STACK_TOP);
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_full_empty();
    test_replace();
    test_interleave();
    test_async_and_enable();
    repeat (2) @(negedge clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected pops never seen", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nstacks_param.md
Name: nstacks_param

Overview:
- Parametrised multi-stack controller: NUM_STACKS independent LIFO stacks, each DEPTH entries of DATA_W bits, in internal register storage.
- One push/pop/replace/clear per clock edge on the stack chosen by STACK_SEL.
- Adds per-stack full/empty, sticky overflow/underflow, combined push+pop replace, and a registered pop-data return path.
- Sits beside the CPU datapath as a hardware call/operand stack bank.

Parameters:
- DATA_W, 32, entry width in bits.
- DEPTH, 16, entries per stack; must be >= 2.
- NUM_STACKS, 4, number of independent stacks; must be >= 1.
- SEL_W (localparam), max(1, $clog2(NUM_STACKS)), stack select width.
- CNT_W (localparam), $clog2(DEPTH+1), occupancy count width.

Ports:
- clock  in  1  system clock; all state updates on falling edge.
- reset_n  in  1  asynchronous, active-low reset.
- STACK_ENB  in  1  operation enable; when 0, no state changes.
- STACK_SEL  in  SEL_W  selects the target stack for operations and status outputs.
- STACK_push_flag  in  1  push request.
- STACK_pop_flag  in  1  pop request.
- STACK_push_value  in  DATA_W  data to push.
- STACK_clear  in  1  empties the selected stack.
- STACK_TOP  out  DATA_W  combinational top entry of the selected stack; 0 when empty.
- STACK_AMOUNT  out  CNT_W  combinational occupancy of the selected stack.
- STACK_FULL  out  1  selected stack count == DEPTH.
- STACK_EMPTY  out  1  selected stack count == 0.
- STACK_pop_data  out  DATA_W  registered value removed by the last successful pop or replace.
- STACK_pop_valid  out  1  one-cycle pulse: STACK_pop_data was updated at this edge.
- STACK_overflow  out  NUM_STACKS  sticky per-stack overflow flags.
- STACK_underflow  out  NUM_STACKS  sticky per-stack underflow flags.

Behaviour:
- Reset (reset_n=0, asynchronous, takes effect immediately, including mid-operation):
  - all counts 0; STACK_pop_data 0; STACK_pop_valid 0; all overflow/underflow flags 0.
  - Storage contents are don't-care.
  - Combinational outputs therefore read TOP=0, AMOUNT=0, EMPTY=1, FULL=0.
- Update timing: operations are sampled and executed on the negedge of clock when reset_n=1 and STACK_ENB=1.
- STACK_pop_valid defaults to 0 every active edge unless set by that edge's operation; it is held at 0 while STACK_ENB=0.
- Operation priority on the selected stack s, count c:
  1. clear: c<=0; overflow[s]<=0; underflow[s]<=0. Push/pop ignored that edge; pop_valid 0.
  2. push&pop, c>0: replace. pop_data<=entry[c-1]; entry[c-1]<=push_value; c unchanged; pop_valid<=1. Legal when full.
  3. push&pop, c==0: acts as push only. entry[0]<=push_value; c<=1; pop_valid 0; no underflow.
  4. push, c<DEPTH: entry[c]<=push_value; c<=c+1.
  5. push, c==DEPTH: ignored; overflow[s]<=1.
  6. pop, c>0: pop_data<=entry[c-1]; c<=c-1; pop_valid<=1.
  7. pop, c==0: ignored; underflow[s]<=1; pop_data held.
- Other stacks are never modified by an operation on s.
- Sticky flags stay set until reset or a clear of that stack.
- STACK_pop_data holds its value until the next successful pop or replace.
- Out-of-range STACK_SEL (>= NUM_STACKS, when NUM_STACKS is not a power of 2):
  - all operations ignored, no flags set;
  - TOP=0, AMOUNT=0, EMPTY=1, FULL=0.
- Arithmetic: counts never wrap; c stays in 0..DEPTH at all times. Entry index is c-1 or c, always in range when used.
- Latency: STACK_TOP, STACK_AMOUNT, STACK_FULL and STACK_EMPTY reflect an operation immediately after the negedge that executes it. STACK_pop_data and STACK_pop_valid are valid from that negedge to the next.

Test Plan:
- Reset, then on stack 0 push 0x11, 0x22, 0x33 -> AMOUNT=3, TOP=0x33. Then pop -> pop_data=0x33, pop_valid pulses one cycle, AMOUNT=2, TOP=0x22.
- DEPTH=16: push 17 values 1..17 on stack 1 -> AMOUNT=16, FULL=1, TOP=16, overflow=4'b0010. Pop 16 times -> values 16..1 returned, EMPTY=1. One more pop -> underflow=4'b0010, pop_data stays 1.
- Stack 2 holds 0xA; assert push(0xB)+pop -> pop_data=0xA, TOP=0xB, AMOUNT=1. On empty stack 3 assert push(0xC)+pop -> AMOUNT=1, pop_valid=0, underflow[3]=0.
- Interleave ops: push 0x5 on stack 0, push 0x6 on stack 3, pop stack 0 -> stack 3 AMOUNT=1, TOP=0x6 unaffected. Clear stack 3 with push asserted -> AMOUNT=0, flags[3] cleared, push ignored.
- With 3 entries and overflow set, assert reset_n=0 between edges -> outputs zero immediately, flags 0. STACK_ENB=0 with push -> no change, pop_valid 0.
